// File: rtl/card_pool_shuffler.sv
// Card pool with a draw pile and a discard pile. Deals 1..MAX_DRAW cards per request, shuffles with an
// LFSR-driven Fisher-Yates and recycles the discard pile when the draw pile runs dry.
module card_pool_shuffler #(
    parameter int DEPTH    = 108,
    parameter int CARD_W   = 6,
    parameter int MAX_DRAW = 4,
    parameter int KEEP_TOP = 1,
    localparam int IDX_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 1),
    localparam int DC_W    = $clog2(MAX_DRAW + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [15:0]       i_seed,
    output logic [IDX_W-1:0]  o_init_idx,
    input  logic [CARD_W-1:0] i_init_card,
    input  logic              i_draw_req,
    input  logic [DC_W-1:0]   i_draw_cnt,
    output logic              o_card_valid,
    output logic [CARD_W-1:0] o_card,
    output logic              o_draw_done,
    output logic              o_short,
    input  logic              i_discard_valid,
    input  logic [CARD_W-1:0] i_discard_card,
    output logic              o_discard_ready,
    output logic              o_ready,
    output logic [CNT_W-1:0]  o_draw_count,
    output logic [CNT_W-1:0]  o_discard_count
);

    typedef enum logic [2:0] {IDLE, LOAD, SHUFFLE, DRAW, RECYCLE, DONE} state_t;

    state_t state, next_state;

    logic [CARD_W-1:0] draw_mem [DEPTH];
    logic [CARD_W-1:0] disc_mem [DEPTH];

    logic [CNT_W-1:0]  draw_count, disc_count;
    logic [15:0]       lfsr;
    logic [IDX_W-1:0]  idx;
    logic [DC_W-1:0]   remaining;
    logic              ret_draw;
    logic              short_flag;
    logic [CARD_W-1:0] card_q;
    logic              card_valid_q;

    logic [15:0]       lfsr_next;
    logic [IDX_W-1:0]  j;
    logic              swap_ok;
    logic              multi;
    logic              shuffle_end;
    logic [IDX_W-1:0]  top_idx;
    logic [IDX_W-1:0]  disc_idx;
    logic [IDX_W-1:0]  disc_top_idx;
    logic [CNT_W-1:0]  recycle_n;
    logic              recycle_last;
    logic              discard_ok;
    logic              disc_write;
    logic [DC_W-1:0]   req_cnt;

    assign lfsr_next    = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign j            = lfsr[IDX_W-1:0];
    assign swap_ok      = (j <= idx);
    assign multi        = (draw_count > CNT_W'(1));
    // The last accepted swap is the one at i == 1; a pile of 0 or 1 cards needs no work.
    assign shuffle_end  = !multi || (swap_ok && (idx == IDX_W'(1)));
    assign top_idx      = IDX_W'(draw_count - 1'b1);
    assign disc_idx     = IDX_W'(disc_count);
    assign disc_top_idx = IDX_W'(disc_count - 1'b1);
    assign recycle_n    = disc_count - CNT_W'(KEEP_TOP);
    assign recycle_last = (CNT_W'(idx) == (recycle_n - CNT_W'(1)));
    assign discard_ok   = (state == IDLE) && (disc_count < CNT_W'(DEPTH));
    assign disc_write   = discard_ok && i_discard_valid;
    assign req_cnt      = (i_draw_cnt > DC_W'(MAX_DRAW)) ? DC_W'(MAX_DRAW) : i_draw_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (i_start)         next_state = LOAD;
                else if (i_draw_req) next_state = (i_draw_cnt == '0) ? DONE : DRAW;
            end
            LOAD:    if (idx == IDX_W'(DEPTH - 1)) next_state = SHUFFLE;
            SHUFFLE: if (shuffle_end) next_state = ret_draw ? DRAW : IDLE;
            DRAW: begin
                if (remaining == '0)                          next_state = DONE;
                else if (draw_count != '0)                    next_state = DRAW;
                else if (disc_count > CNT_W'(KEEP_TOP))       next_state = RECYCLE;
                else                                          next_state = DONE;
            end
            RECYCLE: if (recycle_last) next_state = SHUFFLE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            draw_count   <= '0;
            disc_count   <= '0;
            lfsr         <= 16'h0001;
            idx          <= '0;
            remaining    <= '0;
            ret_draw     <= 1'b0;
            short_flag   <= 1'b0;
            card_q       <= '0;
            card_valid_q <= 1'b0;
        end else begin
            card_valid_q <= 1'b0;
            if (state == SHUFFLE) lfsr <= lfsr_next;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        lfsr       <= (i_seed == 16'h0000) ? 16'h0001 : i_seed;
                        disc_count <= '0;
                        idx        <= '0;
                    end else begin
                        if (disc_write) disc_count <= disc_count + 1'b1;
                        if (i_draw_req) begin
                            remaining  <= req_cnt;
                            short_flag <= 1'b0;
                        end
                    end
                end
                LOAD: begin
                    idx <= idx + 1'b1;
                    if (idx == IDX_W'(DEPTH - 1)) begin
                        draw_count <= CNT_W'(DEPTH);
                        idx        <= IDX_W'(DEPTH - 1);
                        ret_draw   <= 1'b0;
                    end
                end
                SHUFFLE: if (multi && swap_ok) idx <= idx - 1'b1;
                DRAW: begin
                    if (remaining != '0) begin
                        if (draw_count != '0) begin
                            card_q       <= draw_mem[top_idx];
                            card_valid_q <= 1'b1;
                            draw_count   <= draw_count - 1'b1;
                            remaining    <= remaining - 1'b1;
                        end else if (disc_count > CNT_W'(KEEP_TOP)) begin
                            idx <= '0;
                        end else begin
                            short_flag <= 1'b1;
                        end
                    end
                end
                RECYCLE: begin
                    idx <= idx + 1'b1;
                    if (recycle_last) begin
                        draw_count <= recycle_n;
                        disc_count <= CNT_W'(KEEP_TOP);
                        idx        <= IDX_W'(recycle_n - CNT_W'(1));
                        ret_draw   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pile storage carries no reset; the counts alone define which entries are live.
    always_ff @(posedge i_clk) begin
        case (state)
            IDLE:    if (disc_write) disc_mem[disc_idx] <= i_discard_card;
            LOAD:    draw_mem[idx] <= i_init_card;
            SHUFFLE: begin
                if (multi && swap_ok) begin
                    draw_mem[idx] <= draw_mem[j];
                    draw_mem[j]   <= draw_mem[idx];
                end
            end
            RECYCLE: begin
                draw_mem[idx] <= disc_mem[idx];
                if ((KEEP_TOP != 0) && recycle_last) disc_mem[0] <= disc_mem[disc_top_idx];
            end
            default: ;
        endcase
    end

    assign o_init_idx      = idx;
    assign o_card_valid    = card_valid_q;
    assign o_card          = card_q;
    assign o_draw_done     = (state == DONE);
    assign o_short         = (state == DONE) && short_flag;
    assign o_discard_ready = discard_ok;
    assign o_ready         = (state == IDLE);
    assign o_draw_count    = draw_count;
    assign o_discard_count = disc_count;

endmodule
